// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter (LSL/LSR/ASR/ROR) for the execute stage.
// Shift layers run MSB-first and are split into S = ceil(L/LAYERS_PER_STAGE)
// register stages. A valid/ready handshake with bubble collapse, a synchronous
// flush and a tag that travels with each operation are provided.
//
// Ports:
//   CLK, RESETn        clock (rising edge), asynchronous active-low reset
//   Flush              synchronous kill of every in-flight operation
//   InValid/InReady    input handshake (InReady is combinational)
//   ShIn, Shamt, ShOp  operand, shift amount, op (00 LSL 01 LSR 10 ASR 11 ROR)
//   InTag              opaque tag carried with the operation
//   OutValid/OutReady  output handshake
//   ShOut, OutTag      result and its tag, straight from the last stage register
//   OutZero            (only with SHIFTER_ZERO_FLAG_EN) registered ShOut == 0 flag
//
// Optional feature macro: SHIFTER_ZERO_FLAG_EN
module barrel_shifter_pipe #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned SHAMT_WIDTH      = $clog2(DATA_WIDTH),
  parameter int unsigned LAYERS_PER_STAGE = 2,
  parameter int unsigned TAG_WIDTH        = 5
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   Flush,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [DATA_WIDTH-1:0]  ShIn,
  input  logic [SHAMT_WIDTH-1:0] Shamt,
  input  logic [1:0]             ShOp,
  input  logic [TAG_WIDTH-1:0]   InTag,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [DATA_WIDTH-1:0]  ShOut,
  output logic [TAG_WIDTH-1:0]   OutTag
`ifdef SHIFTER_ZERO_FLAG_EN
  ,
  output logic                   OutZero
`endif
);

  localparam int unsigned L = SHAMT_WIDTH;
  localparam int unsigned S = (L + LAYERS_PER_STAGE - 1) / LAYERS_PER_STAGE;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Stage registers
  logic [S-1:0]           valid_q, valid_d;
  logic [DATA_WIDTH-1:0]  data_q  [S];
  logic [DATA_WIDTH-1:0]  data_d  [S];
  logic [1:0]             op_q    [S];
  logic [1:0]             op_d    [S];
  logic [S-1:0]           sign_q, sign_d;
  logic [SHAMT_WIDTH-1:0] shamt_q [S];
  logic [SHAMT_WIDTH-1:0] shamt_d [S];
  logic [TAG_WIDTH-1:0]   tag_q   [S];
  logic [TAG_WIDTH-1:0]   tag_d   [S];

  // Per-stage upstream view (input port for stage 0, previous register otherwise)
  logic [S-1:0]           src_valid_c;
  logic [DATA_WIDTH-1:0]  src_data_c  [S];
  logic [1:0]             src_op_c    [S];
  logic [S-1:0]           src_sign_c;
  logic [SHAMT_WIDTH-1:0] src_shamt_c [S];
  logic [TAG_WIDTH-1:0]   src_tag_c   [S];

  logic [S:0]             ready_c;
  logic [S-1:0]           load_c;

  // Apply the layers owned by one stage; layer k shifts by 2^(L-1-k).
  function automatic logic [DATA_WIDTH-1:0] run_stage(
    input logic [DATA_WIDTH-1:0]  din,
    input logic [1:0]             op,
    input logic                   sign,
    input logic [SHAMT_WIDTH-1:0] shamt,
    input int unsigned            stage
  );
    logic [DATA_WIDTH-1:0]  r;
    logic [DATA_WIDTH-1:0]  ones;
    logic [SHAMT_WIDTH-1:0] mask;
    int unsigned            k;
    int unsigned            amt;
    r    = din;
    ones = '1;
    for (int unsigned j = 0; j < LAYERS_PER_STAGE; j++) begin
      k = stage * LAYERS_PER_STAGE + j;
      if (k < L) begin
        mask = SHAMT_WIDTH'(1) << (L - 1 - k);
        amt  = 32'd1 << (L - 1 - k);
        if ((shamt & mask) != '0) begin
          case (op)
            OP_LSL: r = r << amt;
            OP_LSR: r = r >> amt;
            OP_ASR: r = (r >> amt) | (sign ? ~(ones >> amt) : '0);
            OP_ROR: r = (r >> amt) | (r << (DATA_WIDTH - amt));
          endcase
        end
      end
    end
    return r;
  endfunction

  // ready_i = !valid_i || ready_(i+1), unrolled so no signal depends on itself
  always_comb begin
    ready_c = '0;
    for (int unsigned i = 0; i <= S; i++) begin
      ready_c[i] = OutReady;
      for (int unsigned j = i; j < S; j++) begin
        if (!valid_q[j]) ready_c[i] = 1'b1;
      end
    end
  end

  assign InReady = ready_c[0];

  // Next-state for every stage
  always_comb begin
    src_valid_c    = '0;
    src_sign_c     = '0;
    load_c         = '0;
    valid_d        = valid_q;
    sign_d         = sign_q;
    src_valid_c[0] = InValid;
    src_data_c[0]  = ShIn;
    src_op_c[0]    = ShOp;
    src_sign_c[0]  = ShIn[DATA_WIDTH-1];
    src_shamt_c[0] = Shamt;
    src_tag_c[0]   = InTag;
    for (int unsigned i = 1; i < S; i++) begin
      src_valid_c[i] = valid_q[i-1];
      src_data_c[i]  = data_q[i-1];
      src_op_c[i]    = op_q[i-1];
      src_sign_c[i]  = sign_q[i-1];
      src_shamt_c[i] = shamt_q[i-1];
      src_tag_c[i]   = tag_q[i-1];
    end
    for (int unsigned i = 0; i < S; i++) begin
      data_d[i]  = data_q[i];
      op_d[i]    = op_q[i];
      shamt_d[i] = shamt_q[i];
      tag_d[i]   = tag_q[i];
      // Payload only moves with a real operation so idle stages stay quiet
      load_c[i]  = ready_c[i] && src_valid_c[i];
      if (ready_c[i]) valid_d[i] = src_valid_c[i];
      if (load_c[i]) begin
        data_d[i]  = run_stage(src_data_c[i], src_op_c[i], src_sign_c[i],
                               src_shamt_c[i], i);
        op_d[i]    = src_op_c[i];
        sign_d[i]  = src_sign_c[i];
        shamt_d[i] = src_shamt_c[i];
        tag_d[i]   = src_tag_c[i];
      end
      if (Flush) valid_d[i] = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      valid_q <= '0;
      sign_q  <= '0;
      for (int unsigned i = 0; i < S; i++) begin
        data_q[i]  <= '0;
        op_q[i]    <= '0;
        shamt_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      sign_q  <= sign_d;
      for (int unsigned i = 0; i < S; i++) begin
        data_q[i]  <= data_d[i];
        op_q[i]    <= op_d[i];
        shamt_q[i] <= shamt_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  // Last-stage control fields are kept for uniformity but nothing reads them
  logic unused_last_ctrl;
  assign unused_last_ctrl = ^{op_q[S-1], sign_q[S-1], shamt_q[S-1]};

  assign OutValid = valid_q[S-1];
  assign ShOut    = data_q[S-1];
  assign OutTag   = tag_q[S-1];

`ifdef SHIFTER_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // Zero flag is derived from the last stage's next data and registered with it
  always_comb begin
    zero_d = zero_q;
    if (load_c[S-1]) zero_d = (data_d[S-1] == '0);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) zero_q <= 1'b0;
    else         zero_q <= zero_d;
  end

  assign OutZero = zero_q;
`endif

endmodule

// File: doc/barrel_shifter_pipe.md
Name: barrel_shifter_pipe

Overview:
- Parametrised, pipelined, multi-mode barrel shifter for the execute stage. Successor to the single-cycle combinational left-shifter.
- Supports LSL, LSR, ASR and ROR over a configurable data width.
- Shift layers are split across register stages. Valid/ready handshake, per-operation tag passthrough and synchronous flush let it run as a multi-cycle functional unit beside the ALU.

Parameters:
- DATA_WIDTH, 32, operand width; power of two, 8..64.
- SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount width; equals the number of shift layers L.
- LAYERS_PER_STAGE, 2, shift layers evaluated between pipeline registers; 1..L.
- TAG_WIDTH, 5, opaque tag carried alongside data (e.g. rd index).

Ports:
- CLK  in  1  clock; all registers on rising edge.
- RESETn  in  1  asynchronous active-low reset.
- Flush  in  1  synchronous kill of all in-flight operations.
- InValid  in  1  input operation valid.
- InReady  out  1  unit can accept an input this cycle.
- ShIn  in  DATA_WIDTH  operand.
- Shamt  in  SHAMT_WIDTH  shift amount; only these bits are used (RISC-V masking).
- ShOp  in  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
- InTag  in  TAG_WIDTH  tag.
- OutValid  out  1  result valid.
- OutReady  in  1  consumer accepts the result.
- ShOut  out  DATA_WIDTH  result.
- OutTag  out  TAG_WIDTH  tag of the result.

Behaviour:
- Layers run MSB-first: layer k shifts by 2^(L-1-k) when the corresponding Shamt bit is set.
  - LSL: zero fill.
  - LSR: zero fill.
  - ASR: fill with the operand sign bit, captured at input.
  - ROR: wrap the bits shifted out back in.
- Pipeline depth S = ceil(L / LAYERS_PER_STAGE); latency = S cycles, input accept to OutValid, with no stalls.
  - Default: L=5, S=3.
- Each stage register holds: valid, partial data, ShOp, sign bit, the unconsumed Shamt bits and the tag.
  - Output is taken straight from the last stage register; there is no combinational logic after it.
- Handshake:
  - Stage i advances when ready_i = !valid_i || ready_(i+1); ready_S = OutReady.
  - InReady = ready_0 (combinational through the chain). Input is accepted when InValid && InReady.
  - A held result keeps ShOut/OutTag stable while OutValid && !OutReady.
  - One operation per cycle is sustained when OutReady is continuously high.
- Bubbles: an empty stage accepts upstream data even while downstream is stalled (bubble collapse). The data/tag of an empty stage is don't-care but must not toggle OutValid.
- Flush:
  - On a clock edge with Flush=1, all valid bits clear.
  - An input presented in the same cycle is dropped, even if InReady=1.
  - Next cycle: OutValid=0, InReady=1.
- Reset: asynchronous assertion clears all valid bits, data, tags and op fields to 0. After release: OutValid=0, ShOut=0, OutTag=0, InReady=1.
- Reset asserted mid-operation discards all in-flight work; there is no partial output.
- Boundary cases:
  - Shamt=0 returns ShIn unchanged for every op.
  - Shamt=DATA_WIDTH-1 with ASR yields all sign bits.
  - ROR by any amount preserves popcount.
  - Undefined ShOp values cannot occur; all four encodings are defined.

Optional Feature:
- Macro: SHIFTER_ZERO_FLAG_EN.
- When defined:
  - Adds output port OutZero (1 bit), asserted when ShOut == 0.
  - Computed at the last stage register input and registered with the result; no output comb path.
  - Reset value 0; held stable under stall like ShOut.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset and defaults: RESETn low mid-stream with 2 ops in flight -> OutValid=0, ShOut=0, OutTag=0 immediately. After release, InReady=1 and no stale result appears.
- Modes, DATA_WIDTH=32, OutReady=1, issued back-to-back, each result 3 cycles after accept and in order:
  - LSL 0x0000_00F1 by 4 -> 0x0000_0F10.
  - LSR 0x8000_0000 by 31 -> 0x0000_0001.
  - ASR 0x8000_0000 by 31 -> 0xFFFF_FFFF.
  - ROR 0x0000_0001 by 1 -> 0x8000_0000.
- Stall and backpressure: 5 ops with tags 1..5, OutReady low for 6 cycles after the first result -> 3 results buffered, then InReady=0. ShOut/OutTag of tag 1 stay constant. On OutReady=1, tags 1..5 drain in order with no loss or duplication.
- Flush: 3 ops in flight and Flush=1 alongside a new InValid -> next cycle OutValid=0, nothing emitted later. An op issued after the flush appears 3 cycles later with the correct value.
- Shamt edge cases: Shamt=0 on all ops with 0xA5A5_5A5A -> unchanged. Random 10k ops with all modes/amounts checked against a reference model. Re-run the suite with DATA_WIDTH=64 and LAYERS_PER_STAGE=1 (latency 6), and with LAYERS_PER_STAGE=5 (latency 1).
- SHIFTER_ZERO_FLAG_EN defined:
  - LSL 0x8000_0000 by 1 -> ShOut=0, OutZero=1.
  - ROR 0x8000_0000 by 1 -> OutZero=0.
